// File: rtl/ac97_frame_feeder.sv
// Purpose: feeds the AC97 link serializer once per frame with codec commands and PCM slots.
// Latency: outputs update on the clock after the frame tick (rising edge of ready); a pushed
//          sample is visible to the next tick at the earliest.
// Backpressure: pcm_full asserted at 2^FIFO_AW entries; writes while full are dropped and set overflow.
//
// Ports:
//   ac97_bit_clock, reset      - bit clock and synchronous active-high reset
//   ready                      - serializer ready; its rising edge is the frame tick
//   pcm_left/right, pcm_wr     - stereo sample write port (one entry per strobe)
//   volume                     - requested attenuation, 0 = loudest, 1.5 dB/step
//   pcm_full, fifo_level       - FIFO status
//   overflow                   - sticky, a write was attempted while full
//   command_address/data/valid - codec register write for the current frame
//   left/right_data/valid      - PCM slots for the current frame (16-bit sample left-justified in 20 bits)
//   init_done                  - codec init sequence has completed
//   underrun_count             - saturating count of frames with no sample available

module ac97_frame_feeder #(
  parameter int          FIFO_AW     = 4,
  parameter logic [7:0]  INIT_FRAMES = 8'd64,
  parameter logic [15:0] PCM_VOL     = 16'h0808
) (
  input  logic               ac97_bit_clock,
  input  logic               reset,
  input  logic               ready,
  input  logic [15:0]        pcm_left,
  input  logic [15:0]        pcm_right,
  input  logic               pcm_wr,
  input  logic [4:0]         volume,
  output logic               pcm_full,
  output logic [FIFO_AW:0]   fifo_level,
  output logic [7:0]         command_address,
  output logic [15:0]        command_data,
  output logic               command_valid,
  output logic [19:0]        left_data,
  output logic               left_valid,
  output logic [19:0]        right_data,
  output logic               right_valid,
  output logic               init_done,
  output logic [7:0]         underrun_count,
  output logic               overflow
);

  localparam int              DEPTH_INT   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH      = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [7:0]      ADDR_MASTER = 8'h02;
  localparam logic [7:0]      ADDR_HP     = 8'h04;
  localparam logic [7:0]      ADDR_PCM    = 8'h18;

  // Master and headphone volume registers share one layout: mute=0, left and
  // right attenuation both set to the requested volume.
  function automatic logic [15:0] vol_word(input logic [4:0] v);
    return {1'b0, 2'b00, v, 3'b000, v};
  endfunction

  // ---------------------------------------------------------------------------
  // Frame tick
  // ---------------------------------------------------------------------------
  logic ready_d;
  logic tick;

  always_ff @(posedge ac97_bit_clock) begin
    if (reset) ready_d <= 1'b0;
    else       ready_d <= ready;
  end

  assign tick = ready & ~ready_d;

  // ---------------------------------------------------------------------------
  // Sample FIFO
  // ---------------------------------------------------------------------------
  logic [31:0]      mem [DEPTH_INT];
  logic [FIFO_AW:0] wr_ptr;
  logic [FIFO_AW:0] rd_ptr;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [31:0]      rd_entry;

  assign fifo_level = wr_ptr - rd_ptr;
  assign pcm_full   = (fifo_level == DEPTH);
  assign fifo_empty = (fifo_level == '0);

  // Full is judged on the registered level, so a write coinciding with a pop
  // while full is still dropped.
  assign push = pcm_wr & ~pcm_full;
  // Empty is judged on the registered level too: no write-to-read bypass.
  assign pop  = tick & init_done & ~fifo_empty;

  assign rd_entry = mem[rd_ptr[FIFO_AW-1:0]];

  // Storage needs no reset; flushing the pointers empties the FIFO.
  always_ff @(posedge ac97_bit_clock) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= {pcm_left, pcm_right};
  end

  always_ff @(posedge ac97_bit_clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)            wr_ptr   <= wr_ptr + 1'b1;
      if (pop)             rd_ptr   <= rd_ptr + 1'b1;
      if (pcm_wr && pcm_full) overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Audio slots: one entry per tick once the codec is initialised
  // ---------------------------------------------------------------------------
  always_ff @(posedge ac97_bit_clock) begin
    if (reset) begin
      left_data      <= '0;
      left_valid     <= 1'b0;
      right_data     <= '0;
      right_valid    <= 1'b0;
      underrun_count <= '0;
    end else if (tick) begin
      if (!init_done) begin
        left_data   <= '0;
        left_valid  <= 1'b0;
        right_data  <= '0;
        right_valid <= 1'b0;
      end else if (!fifo_empty) begin
        left_data   <= {rd_entry[31:16], 4'h0};
        left_valid  <= 1'b1;
        right_data  <= {rd_entry[15:0], 4'h0};
        right_valid <= 1'b1;
      end else begin
        left_data   <= '0;
        left_valid  <= 1'b0;
        right_data  <= '0;
        right_valid <= 1'b0;
        if (underrun_count != 8'hFF) underrun_count <= underrun_count + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Command sequencer: init writes after the power-up wait, then volume
  // refreshes whenever the requested volume differs from what was last sent.
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_MASTER = 3'd1,
    S_HP     = 3'd2,
    S_PCM    = 3'd3,
    S_IDLE   = 3'd4
  } state_t;

  state_t     state;
  logic [7:0] wait_cnt;
  logic [4:0] vol_sent;
  logic       vol_update;  // set while a post-init volume refresh is in flight

  always_ff @(posedge ac97_bit_clock) begin
    if (reset) begin
      state           <= S_WAIT;
      wait_cnt        <= '0;
      vol_sent        <= '0;
      vol_update      <= 1'b0;
      command_address <= '0;
      command_data    <= '0;
      command_valid   <= 1'b0;
      init_done       <= 1'b0;
    end else if (tick) begin
      // Every command lasts exactly one frame; states that issue one re-assert it.
      command_valid <= 1'b0;
      case (state)
        S_WAIT: begin
          if (wait_cnt == INIT_FRAMES - 8'd1) begin
            wait_cnt <= '0;
            state    <= S_MASTER;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_MASTER: begin
          // The volume sampled here is used for the whole master/headphone pair,
          // so a change mid-sequence is picked up again from IDLE.
          command_address <= ADDR_MASTER;
          command_data    <= vol_word(volume);
          command_valid   <= 1'b1;
          vol_sent        <= volume;
          state           <= S_HP;
        end
        S_HP: begin
          command_address <= ADDR_HP;
          command_data    <= vol_word(vol_sent);
          command_valid   <= 1'b1;
          vol_update      <= 1'b0;
          state           <= vol_update ? S_IDLE : S_PCM;
        end
        S_PCM: begin
          command_address <= ADDR_PCM;
          command_data    <= PCM_VOL;
          command_valid   <= 1'b1;
          init_done       <= 1'b1;
          state           <= S_IDLE;
        end
        S_IDLE: begin
          if (volume != vol_sent) begin
            vol_update <= 1'b1;
            state      <= S_MASTER;
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ac97_frame_feeder.sv
// Purpose: randomized scoreboard bench for ac97_frame_feeder against a frame-level reference model.
// Latency: expectations are queued when ready is raised; the monitor checks one clock later.
// Backpressure: the model drops writes beyond 16 stored entries and tracks the sticky overflow.

module tb_ac97_frame_feeder;

  localparam int INIT = 64;
  localparam int AW   = 4;
  localparam int DEP  = 1 << AW;

  logic          ac97_bit_clock;
  logic          reset;
  logic          ready;
  logic [15:0]   pcm_left;
  logic [15:0]   pcm_right;
  logic          pcm_wr;
  logic [4:0]    volume;
  logic          pcm_full;
  logic [AW:0]   fifo_level;
  logic [7:0]    command_address;
  logic [15:0]   command_data;
  logic          command_valid;
  logic [19:0]   left_data;
  logic          left_valid;
  logic [19:0]   right_data;
  logic          right_valid;
  logic          init_done;
  logic [7:0]    underrun_count;
  logic          overflow;

  ac97_frame_feeder #(
    .FIFO_AW(AW),
    .INIT_FRAMES(8'(INIT)),
    .PCM_VOL(16'h0808)
  ) dut (
    .ac97_bit_clock (ac97_bit_clock),
    .reset          (reset),
    .ready          (ready),
    .pcm_left       (pcm_left),
    .pcm_right      (pcm_right),
    .pcm_wr         (pcm_wr),
    .volume         (volume),
    .pcm_full       (pcm_full),
    .fifo_level     (fifo_level),
    .command_address(command_address),
    .command_data   (command_data),
    .command_valid  (command_valid),
    .left_data      (left_data),
    .left_valid     (left_valid),
    .right_data     (right_data),
    .right_valid    (right_valid),
    .init_done      (init_done),
    .underrun_count (underrun_count),
    .overflow       (overflow)
  );

  initial begin
    ac97_bit_clock = 1'b0;
    forever #5 ac97_bit_clock = ~ac97_bit_clock;
  end

  typedef struct packed {
    logic        cv;
    logic [7:0]  ca;
    logic [15:0] cd;
    logic        lv;
    logic [19:0] ld;
    logic        rv;
    logic [19:0] rd;
    logic [7:0]  und;
    logic        idn;
  } frame_t;

  frame_t exp_q[$];
  int     n_cmp = 0;
  int     n_bad = 0;

  // ---------------------------------------------------------------------------
  // Reference model: frame-numbered schedule of codec writes plus a sample queue
  // ---------------------------------------------------------------------------
  logic [31:0] mq[$];
  int          tick_n;
  bit          m_init;
  bit          m_ovf;
  bit          upd_pend;
  bit          upd_hp;
  logic [4:0]  m_vs;
  logic [7:0]  m_addr;
  logic [15:0] m_data;
  int          m_und;

  function automatic logic [15:0] vw(input logic [4:0] v);
    return {3'b000, v, 3'b000, v};
  endfunction

  task automatic model_reset();
    mq.delete();
    tick_n = 0; m_init = 0; m_ovf = 0; upd_pend = 0; upd_hp = 0;
    m_vs = '0; m_addr = '0; m_data = '0; m_und = 0;
  endtask

  task automatic model_tick(output frame_t e);
    logic [31:0] x;
    e = '0;
    // Audio slot uses the init status that held before this frame.
    if (m_init) begin
      if (mq.size() > 0) begin
        x = mq.pop_front();
        e.lv = 1'b1; e.ld = {x[31:16], 4'h0};
        e.rv = 1'b1; e.rd = {x[15:0], 4'h0};
      end else if (m_und < 255) begin
        m_und++;
      end
    end
    tick_n++;
    if (!m_init) begin
      if (tick_n == INIT + 1) begin
        m_vs = volume; m_addr = 8'h02; m_data = vw(m_vs); e.cv = 1'b1;
      end else if (tick_n == INIT + 2) begin
        m_addr = 8'h04; m_data = vw(m_vs); e.cv = 1'b1;
      end else if (tick_n == INIT + 3) begin
        m_addr = 8'h18; m_data = 16'h0808; e.cv = 1'b1; m_init = 1;
      end
    end else if (upd_hp) begin
      m_addr = 8'h04; m_data = vw(m_vs); e.cv = 1'b1; upd_hp = 0;
    end else if (upd_pend) begin
      m_vs = volume; m_addr = 8'h02; m_data = vw(m_vs); e.cv = 1'b1;
      upd_pend = 0; upd_hp = 1;
    end else if (volume != m_vs) begin
      upd_pend = 1;
    end
    e.ca  = m_addr;
    e.cd  = m_data;
    e.und = 8'(m_und);
    e.idn = m_init;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic frame();
    frame_t e;
    @(negedge ac97_bit_clock);
    model_tick(e);
    exp_q.push_back(e);
    ready = 1'b1;
    repeat (8) @(negedge ac97_bit_clock);
    ready = 1'b0;
    repeat (7) @(negedge ac97_bit_clock);
  endtask

  task automatic do_write(input logic [15:0] l, input logic [15:0] r);
    @(negedge ac97_bit_clock);
    pcm_left = l; pcm_right = r; pcm_wr = 1'b1;
    if (mq.size() >= DEP) m_ovf = 1;
    else mq.push_back({l, r});
    @(negedge ac97_bit_clock);
    pcm_wr = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge ac97_bit_clock);
    reset = 1'b1;
    @(negedge ac97_bit_clock);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_cmd_valid"}, 32'(command_valid), 0);
    chk({tag, "_cmd_addr"},  32'(command_address), 0);
    chk({tag, "_cmd_data"},  32'(command_data), 0);
    chk({tag, "_left"},      32'({left_valid, left_data}), 0);
    chk({tag, "_right"},     32'({right_valid, right_data}), 0);
    chk({tag, "_init_done"}, 32'(init_done), 0);
    chk({tag, "_underrun"},  32'(underrun_count), 0);
    chk({tag, "_overflow"},  32'(overflow), 0);
    chk({tag, "_level"},     32'(fifo_level), 0);
    chk({tag, "_full"},      32'(pcm_full), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: on each observed tick, compare the frame outputs to the queue head
  // ---------------------------------------------------------------------------
  initial begin
    bit     prev;
    int     fno;
    frame_t got;
    frame_t e;
    prev = 1'b0;
    fno  = 0;
    forever begin
      @(posedge ac97_bit_clock);
      #1;
      if (ready && !prev) begin
        fno++;
        got = '{command_valid, command_address, command_data, left_valid, left_data,
                right_valid, right_data, underrun_count, init_done};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL frame%0d: tick seen with no expectation queued", fno);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            n_bad++;
            $display("FAIL frame%0d: got cmd %0b/%02h/%04h L %0b/%05h R %0b/%05h und %0d init %0b, expected cmd %0b/%02h/%04h L %0b/%05h R %0b/%05h und %0d init %0b",
                     fno, got.cv, got.ca, got.cd, got.lv, got.ld, got.rv, got.rd, got.und, got.idn,
                     e.cv, e.ca, e.cd, e.lv, e.ld, e.rv, e.rd, e.und, e.idn);
          end
        end
      end
      prev = ready;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1'b1; ready = 1'b0; pcm_wr = 1'b0;
    pcm_left = '0; pcm_right = '0; volume = 5'd0;
    model_reset();
    repeat (3) @(negedge ac97_bit_clock);
    reset = 1'b0;
    check_zero("reset");

    // Power-up wait and init writes, then a few starved frames.
    repeat (INIT + 3 + 3) frame();

    // Directed four-entry burst.
    do_write(16'h1234, 16'hFEDC);
    do_write(16'h1235, 16'hFEDD);
    do_write(16'h8000, 16'h7FFF);
    do_write(16'h0001, 16'hFFFF);
    chk("burst_level", 32'(fifo_level), 4);
    repeat (6) frame();

    // Fill past capacity with no ticks.
    for (int i = 0; i < DEP; i++) begin
      do_write(16'($urandom), 16'($urandom));
      if (i == DEP - 2) chk("not_full_at_15", 32'(pcm_full), 0);
    end
    chk("full_at_16", 32'(pcm_full), 1);
    chk("no_ovf_at_16", 32'(overflow), 0);
    do_write(16'hDEAD, 16'hBEEF);
    chk("ovf_after_17", 32'(overflow), 32'(m_ovf));
    chk("level_after_17", 32'(fifo_level), DEP);
    repeat (DEP + 2) frame();

    // Volume change in IDLE while audio keeps flowing.
    do_write(16'h0A0A, 16'h5050);
    do_write(16'h0B0B, 16'h6060);
    do_write(16'h0C0C, 16'h7070);
    volume = 5'h0A;
    repeat (5) frame();

    // Randomized traffic with occasional volume changes.
    for (int f = 0; f < 40; f++) begin
      int nw;
      nw = $urandom_range(0, 2);
      for (int k = 0; k < nw; k++) do_write(16'($urandom), 16'($urandom));
      if ($urandom_range(0, 5) == 0) volume = 5'($urandom);
      frame();
    end
    chk("ovf_sticky", 32'(overflow), 32'(m_ovf));

    // Mid-stream reset with entries queued.
    for (int k = 0; k < 5; k++) do_write(16'($urandom), 16'($urandom));
    chk("pre_reset_level", 32'(fifo_level), 32'(mq.size()));
    pulse_reset();
    check_zero("midreset");
    repeat (INIT + 3 + 2) frame();

    // Long starvation: underrun counter saturates.
    repeat (300) frame();
    chk("underrun_sat", 32'(underrun_count), 32'hFF);

    repeat (4) @(negedge ac97_bit_clock);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
